branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL clear immediately when rst_n falls, independent of clk.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- XLEN, 32, operand width.
- BHT_DEPTH, 16, branch-history-table entries; power of 2, minimum 2.
- IDX_W, log2(BHT_DEPTH), table index width.
- CNT_W, 32, performance-counter width.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- IF_idx_i, in, IDX_W, lookup index (PC bits) for the fetch-stage prediction.
- Pred_taken_o, out, 1, fetch-stage prediction.
- ID_Branch_i, in, 1, ID instruction is a conditional branch.
- func3_i, in, 3, branch funct3.
- RS1data_i / RS2data_i, in, XLEN, operands (forwarded values).
- ID_idx_i, in, IDX_W, table index of the ID branch.
- ID_pred_taken_i, in, 1, prediction made for the ID branch at fetch.
- Stall_i, in, 1, ID stage frozen this cycle.
- Clear_cnt_i, in, 1, synchronous clear of the performance counters.
- Branch_o, out, 1, branch taken.
- Mispredict_o, out, 1, resolved direction differs from the prediction.
- Illegal_o, out, 1, unsupported funct3 on a branch.
- Branch_cnt_o / Mispredict_cnt_o, out, CNT_W, performance counters.

Function
REQ-004 The block SHALL decode func3_i as follows:
- 000 BEQ (equal).
- 001 BNE (not equal).
- 100 BLT (signed less-than).
- 101 BGE (signed greater-or-equal).
- 110 BLTU (unsigned less-than).
- 111 BGEU (unsigned greater-or-equal).
- 010 and 011 invalid.
REQ-005 Signed compares SHALL treat bit XLEN-1 as the sign bit; unsigned compares SHALL use the full XLEN bits.
REQ-006 Branch_o SHALL be combinational (zero latency) and equal ID_Branch_i AND valid funct3 AND compare true; it SHALL ignore Stall_i.
REQ-007 Illegal_o SHALL be combinational and equal ID_Branch_i AND (func3_i is 010 or 011); in that case Branch_o SHALL be 0.
REQ-008 A resolve event SHALL be defined as ID_Branch_i=1, Stall_i=0 and valid funct3.
REQ-009 Mispredict_o SHALL be combinational and equal resolve event AND (Branch_o != ID_pred_taken_i).
REQ-010 The BHT SHALL hold BHT_DEPTH 2-bit saturating counters with states SNT=00, WNT=01, WT=10, ST=11.
REQ-011 On each clk edge with a resolve event, entry ID_idx_i SHALL be updated:
- Taken: SNT->WNT->WT->ST, and ST stays ST.
- Not taken: ST->WT->WNT->SNT, and SNT stays SNT.
REQ-012 No other BHT entry SHALL change on that edge, and no entry SHALL change without a resolve event.
REQ-013 Pred_taken_o SHALL be combinational and equal bit 1 of entry IF_idx_i.
REQ-014 When IF_idx_i equals an ID_idx_i being updated in the same cycle, Pred_taken_o SHALL reflect the pre-update value (no bypass).
REQ-015 Branch_cnt_o SHALL increment by 1 on each resolve event with Branch_o=1.
REQ-016 Mispredict_cnt_o SHALL increment by 1 on each edge where Mispredict_o=1.
REQ-017 Both counters SHALL saturate at all-ones and never wrap.
REQ-018 Clear_cnt_i=1 SHALL zero both counters on the next edge, taking priority over a simultaneous increment.
REQ-019 Stall_i=1 SHALL block all BHT and counter updates for that cycle; combinational outputs other than Mispredict_o SHALL still evaluate.

Reset
REQ-020 While rst_n=0, all BHT entries SHALL be WNT (01) and both counters SHALL be 0.
REQ-021 While rst_n=0, Pred_taken_o SHALL be 0.
REQ-022 Reset asserted mid-update SHALL discard the update; the first edge after rst_n rises SHALL behave as normal operation.
REQ-023 Branch_o, Illegal_o and Mispredict_o SHALL have no reset value and follow their inputs (Mispredict_o follows the BHT-independent ID_pred_taken_i).

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Compare decode: RS1=0xFFFFFFFF, RS2=0x00000001, func3=100 -> Branch_o=1; func3=110 -> Branch_o=0; func3=101 -> 0; func3=111 -> 1. Equal operands with func3=000 -> 1; func3=001 -> 0.
- Illegal funct3: func3=010, ID_Branch_i=1 -> Illegal_o=1, Branch_o=0, Mispredict_o=0; BHT and counters unchanged after the edge.
- Saturation: after reset, 3 taken resolves at idx 5 -> entry 5 = ST and Pred_taken_o=1 with IF_idx_i=5; a 4th taken stays ST; 2 not-taken -> WNT and Pred_taken_o=0; entry 4 stays WNT throughout.
- Stall and same-index read: Stall_i=1 with a taken branch -> Branch_o=1 but no BHT or counter change. Update idx 3 while IF_idx_i=3 -> old prediction that cycle, new value the next cycle.
- Counters: CNT_W=4, 20 taken mispredicted resolves -> both counters = 0xF. Clear_cnt_i with a simultaneous mispredict -> both 0 next cycle.
- Async reset: assert rst_n low between edges after training -> counters 0 and all entries WNT immediately, without a clk edge.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: resolves conditional branches in ID, trains a
// table of 2-bit saturating direction predictors, predicts for the fetch
// stage, and keeps saturating branch / mispredict performance counters.
module branch_resolve_unit #(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_W     = $clog2(BHT_DEPTH),
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] IF_idx_i,
    output logic             Pred_taken_o,
    input  logic             ID_Branch_i,
    input  logic [2:0]       func3_i,
    input  logic [XLEN-1:0]  RS1data_i,
    input  logic [XLEN-1:0]  RS2data_i,
    input  logic [IDX_W-1:0] ID_idx_i,
    input  logic             ID_pred_taken_i,
    input  logic             Stall_i,
    input  logic             Clear_cnt_i,
    output logic             Branch_o,
    output logic             Mispredict_o,
    output logic             Illegal_o,
    output logic [CNT_W-1:0] Branch_cnt_o,
    output logic [CNT_W-1:0] Mispredict_cnt_o
);

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    logic [1:0]       r_bht [BHT_DEPTH];
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispredict_cnt;

    logic             w_eq;
    logic             w_lt;
    logic             w_ltu;
    logic             w_cmp;
    logic             w_valid_f3;
    logic             w_resolve;
    logic [1:0]       w_entry;
    logic [1:0]       w_entry_next;

    assign w_eq       = (RS1data_i == RS2data_i);
    assign w_lt       = ($signed(RS1data_i) < $signed(RS2data_i));
    assign w_ltu      = (RS1data_i < RS2data_i);
    // 010 and 011 are the only holes in the branch funct3 space
    assign w_valid_f3 = (func3_i[2:1] != 2'b01);

    // Evaluate the branch condition selected by funct3
    always_comb begin
        w_cmp = 1'b0;
        case (func3_i)
            3'b000:  w_cmp = w_eq;
            3'b001:  w_cmp = ~w_eq;
            3'b100:  w_cmp = w_lt;
            3'b101:  w_cmp = ~w_lt;
            3'b110:  w_cmp = w_ltu;
            3'b111:  w_cmp = ~w_ltu;
            default: w_cmp = 1'b0;
        endcase
    end

    assign Branch_o     = ID_Branch_i & w_valid_f3 & w_cmp;
    assign Illegal_o    = ID_Branch_i & ~w_valid_f3;
    assign w_resolve    = ID_Branch_i & ~Stall_i & w_valid_f3;
    assign Mispredict_o = w_resolve & (Branch_o != ID_pred_taken_i);

    // Read straight from the table: a same-cycle update is not bypassed
    assign Pred_taken_o = r_bht[IF_idx_i][1];

    assign w_entry = r_bht[ID_idx_i];

    // Saturating step of the entry being resolved
    always_comb begin
        w_entry_next = w_entry;
        if (Branch_o) begin
            case (w_entry)
                SNT:     w_entry_next = WNT;
                WNT:     w_entry_next = WT;
                default: w_entry_next = ST;
            endcase
        end else begin
            case (w_entry)
                ST:      w_entry_next = WT;
                WT:      w_entry_next = WNT;
                default: w_entry_next = SNT;
            endcase
        end
    end

    // Predictor table: reset to weakly-not-taken, train only on resolve
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= WNT;
            end
        end else if (w_resolve) begin
            r_bht[ID_idx_i] <= w_entry_next;
        end
    end

    // Taken-branch counter; a stalled cycle leaves it (and its clear) alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
        end else if (!Stall_i) begin
            if (Clear_cnt_i) begin
                r_branch_cnt <= '0;
            end else if (w_resolve && Branch_o && !(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Mispredict counter, same clear/saturation behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mispredict_cnt <= '0;
        end else if (!Stall_i) begin
            if (Clear_cnt_i) begin
                r_mispredict_cnt <= '0;
            end else if (Mispredict_o && !(&r_mispredict_cnt)) begin
                r_mispredict_cnt <= r_mispredict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign Branch_cnt_o     = r_branch_cnt;
    assign Mispredict_cnt_o = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (counters narrowed to 4 bits).
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [IDX_W-1:0] IF_idx_i;
    logic             Pred_taken_o;
    logic             ID_Branch_i;
    logic [2:0]       func3_i;
    logic [XLEN-1:0]  RS1data_i;
    logic [XLEN-1:0]  RS2data_i;
    logic [IDX_W-1:0] ID_idx_i;
    logic             ID_pred_taken_i;
    logic             Stall_i;
    logic             Clear_cnt_i;
    logic             Branch_o;
    logic             Mispredict_o;
    logic             Illegal_o;
    logic [CNT_W-1:0] Branch_cnt_o;
    logic [CNT_W-1:0] Mispredict_cnt_o;

    int checks;
    int errors;
    int exp_bc;
    int exp_mc;

    branch_resolve_unit #(
        .XLEN(XLEN), .BHT_DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_idx_i(IF_idx_i), .Pred_taken_o(Pred_taken_o),
        .ID_Branch_i(ID_Branch_i), .func3_i(func3_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
        .ID_idx_i(ID_idx_i), .ID_pred_taken_i(ID_pred_taken_i),
        .Stall_i(Stall_i), .Clear_cnt_i(Clear_cnt_i),
        .Branch_o(Branch_o), .Mispredict_o(Mispredict_o), .Illegal_o(Illegal_o),
        .Branch_cnt_o(Branch_cnt_o), .Mispredict_cnt_o(Mispredict_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_bcnt"}, 32'(Branch_cnt_o), 32'(exp_bc));
        chk({tag, "_mcnt"}, 32'(Mispredict_cnt_o), 32'(exp_mc));
    endtask

    task automatic pred_at(input string tag, input int idx, input logic exp);
        IF_idx_i = IDX_W'(idx);
        #1;
        chk(tag, 32'(Pred_taken_o), 32'(exp));
    endtask

    // One unstalled BEQ resolve; equal operands => taken
    task automatic resolve(input int idx, input logic taken, input logic pred);
        ID_Branch_i     = 1'b1;
        Stall_i         = 1'b0;
        func3_i         = 3'b000;
        RS1data_i       = 32'h1234;
        RS2data_i       = taken ? 32'h1234 : 32'h4321;
        ID_idx_i        = IDX_W'(idx);
        ID_pred_taken_i = pred;
        @(posedge clk);
        #1;
        ID_Branch_i = 1'b0;
        if (taken && exp_bc < 15) exp_bc++;
        if ((taken != pred) && exp_mc < 15) exp_mc++;
    endtask

    initial begin
        checks = 0; errors = 0; exp_bc = 0; exp_mc = 0;
        rst_n = 1'b0; IF_idx_i = '0; ID_Branch_i = 1'b0; func3_i = '0;
        RS1data_i = '0; RS2data_i = '0; ID_idx_i = '0; ID_pred_taken_i = 1'b0;
        Stall_i = 1'b0; Clear_cnt_i = 1'b0;
        #3;
        chk("rst_pred", 32'(Pred_taken_o), 32'd0);
        chk_cnts("rst");
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Compare decode under stall so nothing is trained
        ID_Branch_i = 1'b1; Stall_i = 1'b1; ID_pred_taken_i = 1'b0;
        RS1data_i = 32'hFFFF_FFFF; RS2data_i = 32'h0000_0001;
        func3_i = 3'b100; #1 chk("blt", 32'(Branch_o), 32'd1);
        chk("stall_mispred", 32'(Mispredict_o), 32'd0);
        func3_i = 3'b110; #1 chk("bltu", 32'(Branch_o), 32'd0);
        func3_i = 3'b101; #1 chk("bge", 32'(Branch_o), 32'd0);
        func3_i = 3'b111; #1 chk("bgeu", 32'(Branch_o), 32'd1);
        RS2data_i = 32'hFFFF_FFFF;
        func3_i = 3'b000; #1 chk("beq", 32'(Branch_o), 32'd1);
        func3_i = 3'b001; #1 chk("bne", 32'(Branch_o), 32'd0);

        // Illegal funct3, unstalled, at idx 2
        @(posedge clk); #1;
        Stall_i = 1'b0; func3_i = 3'b010; ID_idx_i = 4'd2; ID_pred_taken_i = 1'b1;
        RS1data_i = 32'h5; RS2data_i = 32'h5;
        #1;
        chk("ill_illegal", 32'(Illegal_o), 32'd1);
        chk("ill_branch", 32'(Branch_o), 32'd0);
        chk("ill_mispred", 32'(Mispredict_o), 32'd0);
        @(posedge clk); #1;
        ID_Branch_i = 1'b0;
        chk_cnts("ill");
        pred_at("ill_pred2", 2, 1'b0);
        resolve(2, 1'b1, 1'b0);
        pred_at("ill_wnt2", 2, 1'b1);

        // Saturation at idx 5
        resolve(5, 1'b1, 1'b0);
        resolve(5, 1'b1, 1'b1);
        resolve(5, 1'b1, 1'b1);
        pred_at("sat_st", 5, 1'b1);
        resolve(5, 1'b1, 1'b1);
        resolve(5, 1'b0, 1'b1);
        pred_at("sat_wt", 5, 1'b1);
        resolve(5, 1'b0, 1'b1);
        pred_at("sat_wnt", 5, 1'b0);
        pred_at("sat_idx4", 4, 1'b0);
        chk_cnts("sat");

        // Stalled taken branch at idx 7
        ID_Branch_i = 1'b1; Stall_i = 1'b1; func3_i = 3'b000;
        RS1data_i = 32'h9; RS2data_i = 32'h9; ID_idx_i = 4'd7; ID_pred_taken_i = 1'b0;
        #1;
        chk("stl_branch", 32'(Branch_o), 32'd1);
        @(posedge clk); #1;
        ID_Branch_i = 1'b0; Stall_i = 1'b0;
        chk_cnts("stl");
        resolve(7, 1'b0, 1'b0);
        resolve(7, 1'b1, 1'b0);
        pred_at("stl_pred7", 7, 1'b0);

        // Same-index read during update of idx 3
        IF_idx_i = 4'd3;
        ID_Branch_i = 1'b1; Stall_i = 1'b0; func3_i = 3'b000;
        RS1data_i = 32'h1; RS2data_i = 32'h1; ID_idx_i = 4'd3; ID_pred_taken_i = 1'b0;
        #1 chk("byp_old", 32'(Pred_taken_o), 32'd0);
        @(posedge clk); #1;
        ID_Branch_i = 1'b0;
        if (exp_bc < 15) exp_bc++;
        if (exp_mc < 15) exp_mc++;
        #1 chk("byp_new", 32'(Pred_taken_o), 32'd1);

        // Counter saturation at 4 bits
        for (int i = 0; i < 20; i++) resolve(9, 1'b1, 1'b0);
        chk("cnt_sat_b", 32'(Branch_cnt_o), 32'hF);
        chk("cnt_sat_m", 32'(Mispredict_cnt_o), 32'hF);

        // Clear beats a simultaneous mispredict
        Clear_cnt_i = 1'b1;
        ID_Branch_i = 1'b1; func3_i = 3'b000; RS1data_i = 32'h2; RS2data_i = 32'h2;
        ID_idx_i = 4'd9; ID_pred_taken_i = 1'b0;
        #1 chk("clr_mispred", 32'(Mispredict_o), 32'd1);
        @(posedge clk); #1;
        Clear_cnt_i = 1'b0; ID_Branch_i = 1'b0;
        exp_bc = 0; exp_mc = 0;
        chk_cnts("clr");

        // Async reset mid-cycle after training
        resolve(9, 1'b1, 1'b0);
        resolve(9, 1'b1, 1'b0);
        pred_at("ar_pre9", 9, 1'b1);
        chk_cnts("ar_pre");
        rst_n = 1'b0;
        exp_bc = 0; exp_mc = 0;
        #1;
        chk_cnts("ar_now");
        chk("ar_pred9", 32'(Pred_taken_o), 32'd0);
        pred_at("ar_pred5", 5, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        resolve(9, 1'b1, 1'b0);
        pred_at("ar_wnt9", 9, 1'b1);
        resolve(5, 1'b0, 1'b0);
        resolve(5, 1'b1, 1'b0);
        pred_at("ar_wnt5", 5, 1'b0);
        chk_cnts("ar_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
